// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receive path.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef struct packed {
        logic       parity_err;
        logic       frame_err;
        logic [7:0] data;
    } rx_entry_t;

    // Two-of-three vote used to decide each bit from the mid-bit samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Clocks per oversample tick; truncating division.
    function automatic int tick_div(input int clk_freq, input int baud_rate, input int oversample);
        return clk_freq / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous show-ahead FIFO of received UART entries.
// Latency: a push is visible at the head on the next clk edge; pop advances the head on the same edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  rx_entry_t              push_dat,
    input  logic                   pop,
    output rx_entry_t              head_dat,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    rx_entry_t       r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign w_do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_do_push = push && (!full || w_do_pop);
    // Head is forced to zero when empty so the outputs read zero out of reset.
    assign head_dat  = empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset because empty masks the head.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote, optional parity, break detect and output FIFO.
// Latency: entry pushed on the stop bit's mid tick, visible at m_valid one clk later.
// Backpressure: m_valid/m_ready at the FIFO head; frames arriving while full are dropped and flagged by overrun.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rx,
    output logic [7:0]                  m_data,
    output logic                        m_frame_err,
    output logic                        m_parity_err,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        overrun,
    output logic                        break_det,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW       = $clog2(OVERSAMPLE);
    localparam int M        = OVERSAMPLE / 2;

    logic [1:0]    r_sync;
    logic [TW-1:0] r_tick_cnt;
    rx_state_t     r_state;
    rx_state_t     w_next;
    logic [SW-1:0] r_s;
    logic [2:0]    r_bit;
    logic [1:0]    r_smp;
    logic [7:0]    r_shift;
    logic          r_parity_err;
    logic          r_overrun;
    logic          r_break;

    logic          w_rx_s;
    logic          w_tick;
    logic          w_mid;
    logic          w_wrap;
    logic          w_maj;
    logic          w_par_odd;
    logic          w_push;
    rx_entry_t     w_entry;
    rx_entry_t     w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;

    assign w_rx_s    = r_sync[1];
    assign w_tick    = (r_tick_cnt == TW'(TICK_DIV - 1));
    assign w_mid     = (r_s == SW'(M + 1));
    assign w_wrap    = (r_s == SW'(OVERSAMPLE - 1));
    // The s=M+1 sample is taken live; the two earlier ones were captured in r_smp.
    assign w_maj     = majority3(r_smp[1], r_smp[0], w_rx_s);
    assign w_par_odd = (PARITY_ODD != 0);

    // Two-flop synchronizer, idling high like the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx};
        end
    end

    // Free-running oversample tick divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: all movement happens on tick cycles only.
    always_comb begin
        w_next = r_state;
        if (w_tick) begin
            case (r_state)
                IDLE:   if (!w_rx_s) w_next = START;
                START: begin
                    if (w_mid && w_maj) begin
                        w_next = IDLE;
                    end else if (w_wrap) begin
                        w_next = DATA;
                    end
                end
                DATA: begin
                    if (w_wrap && (r_bit == 3'd7)) begin
                        w_next = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
                PARITY: if (w_wrap) w_next = STOP;
                STOP:   if (w_mid) w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // FSM outputs: push the completed frame on the stop bit's vote tick.
    always_comb begin
        w_push           = w_tick && (r_state == STOP) && w_mid;
        w_entry          = '0;
        w_entry.parity_err = r_parity_err;
        w_entry.frame_err  = !w_maj;
        w_entry.data       = r_shift;
    end

    // Bit-timing datapath: sample counter, vote samples, shift register, parity.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s          <= '0;
            r_bit        <= '0;
            r_smp        <= 2'b11;
            r_shift      <= '0;
            r_parity_err <= 1'b0;
        end else if (w_tick) begin
            if (r_state == IDLE) begin
                r_s          <= '0;
                r_bit        <= '0;
                r_parity_err <= 1'b0;
            end else begin
                r_s <= w_wrap ? '0 : r_s + SW'(1);
                if (r_s == SW'(M - 1)) r_smp[1] <= w_rx_s;
                if (r_s == SW'(M))     r_smp[0] <= w_rx_s;
                if (w_mid && (r_state == DATA)) begin
                    r_shift <= {w_maj, r_shift[7:1]};
                end
                if (w_mid && (r_state == PARITY)) begin
                    r_parity_err <= (^r_shift) ^ w_maj ^ w_par_odd;
                end
                if (w_wrap && (r_state == DATA)) begin
                    r_bit <= r_bit + 3'd1;
                end
            end
        end
    end

    // Status pulses registered one clk after the push decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_break   <= 1'b0;
        end else begin
            r_overrun <= w_push && w_full && !w_pop;
            r_break   <= w_push && w_entry.frame_err && (w_entry.data == 8'h00);
        end
    end

    assign w_pop = !w_empty && m_ready;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (w_push),
        .push_dat (w_entry),
        .pop      (w_pop),
        .head_dat (w_head),
        .full     (w_full),
        .empty    (w_empty),
        .count    (fifo_count)
    );

    assign m_valid      = !w_empty;
    assign m_data       = w_head.data;
    assign m_frame_err  = w_head.frame_err;
    assign m_parity_err = w_head.parity_err;
    assign overrun      = r_overrun;
    assign break_det    = r_break;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: bit-level line driver, expected-entry queue, per-feature tasks.
// Clock scaled so TICK_DIV=4 and one bit is 64 clk, keeping runs short.
// Two instances: no parity (main) and even parity (dut_p).
module tb_uart_rx_os;
    import uart_pkg::*;

    localparam int CLK_FREQ  = 7_372_800;
    localparam int BAUD      = 115200;
    localparam int OS        = 16;
    localparam int DEPTH     = 8;
    localparam int BIT_CLK   = 64;
    localparam int RX_BUDGET = 2000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx, rx_p;
    logic       m_ready, m_ready_p;
    logic [7:0] m_data, m_data_p;
    logic       m_frame_err, m_frame_err_p, m_parity_err, m_parity_err_p;
    logic       m_valid, m_valid_p, overrun, overrun_p, break_det, break_det_p;
    logic [3:0] fifo_count, fifo_count_p;

    int checks = 0;
    int errors = 0;
    int pop_cnt = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;
    logic [9:0] sb[$];

    always #5 clk = ~clk;

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .m_data(m_data), .m_frame_err(m_frame_err),
        .m_parity_err(m_parity_err), .m_valid(m_valid), .m_ready(m_ready),
        .overrun(overrun), .break_det(break_det), .fifo_count(fifo_count));

    uart_rx_os #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
                 .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(DEPTH)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx_p), .m_data(m_data_p), .m_frame_err(m_frame_err_p),
        .m_parity_err(m_parity_err_p), .m_valid(m_valid_p), .m_ready(m_ready_p),
        .overrun(overrun_p), .break_det(break_det_p), .fifo_count(fifo_count_p));

    // Event counters for the main instance.
    always @(posedge clk) begin
        if (m_valid && m_ready) pop_cnt <= pop_cnt + 1;
        if (overrun)            ovr_cnt <= ovr_cnt + 1;
        if (break_det)          brk_cnt <= brk_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive_bit(input bit sel, input logic b);
        if (sel) rx_p = b; else rx = b;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                              input bit par_bit, input bit stop_bit);
        drive_bit(sel, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
        if (par_en) drive_bit(sel, par_bit);
        drive_bit(sel, stop_bit);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; rx = 1'b1; rx_p = 1'b1; m_ready = 1'b1; m_ready_p = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL reset_m_data: got %h want 00", m_data); end
        checks++; if (m_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b want 0", m_frame_err); end
        checks++; if (m_parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err: got %b want 0", m_parity_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (break_det !== 1'b0) begin errors++; $display("FAIL reset_break: got %b want 0", break_det); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if (m_valid_p !== 1'b0) begin errors++; $display("FAIL reset_p_valid: got %b want 0", m_valid_p); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [4];
        int o0;
        bytes[0] = 8'hA5; bytes[1] = 8'h5A; bytes[2] = 8'h00; bytes[3] = 8'hFF;
        sb.delete(); o0 = ovr_cnt;
        for (int i = 0; i < 4; i++) sb.push_back({2'b00, bytes[i]});
        fork
            for (int i = 0; i < 4; i++) send_frame(1'b0, bytes[i], 1'b0, 1'b0, 1'b1);
            for (int k = 0; k < 4; k++) begin
                int wd; logic [9:0] ex;
                wd = 0;
                while (!m_valid && wd < RX_BUDGET) begin @(negedge clk); wd++; end
                checks++;
                if (!m_valid) begin errors++; $display("FAIL b2b_timeout: entry %0d m_valid=0 want 1", k); end
                else begin
                    ex = sb.pop_front();
                    if (m_data !== ex[7:0]) begin errors++; $display("FAIL b2b_data: got %h want %h", m_data, ex[7:0]); end
                    checks++; if (m_frame_err !== ex[8]) begin errors++; $display("FAIL b2b_frame_err: got %b want %b", m_frame_err, ex[8]); end
                    checks++; if (m_parity_err !== ex[9]) begin errors++; $display("FAIL b2b_parity_err: got %b want %b", m_parity_err, ex[9]); end
                    @(negedge clk);
                end
            end
        join
        checks++; if (ovr_cnt != o0) begin errors++; $display("FAIL b2b_overrun: got %0d pulses want 0", ovr_cnt - o0); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL b2b_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pop_cnt;
        rx = 1'b0;
        repeat (12) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d want IDLE", dut.r_state); end
        checks++; if (fifo_count !== 4'd0) begin errors++; $display("FAIL glitch_count: got %0d want 0", fifo_count); end
        checks++; if (pop_cnt != p0) begin errors++; $display("FAIL glitch_pops: got %0d want 0", pop_cnt - p0); end
    endtask

    task automatic test_parity();
        logic [1:0] pbits;
        pbits = 2'b01;
        sb.delete();
        sb.push_back({1'b1, 1'b0, 8'h03});
        sb.push_back({1'b0, 1'b0, 8'h03});
        fork
            for (int i = 0; i < 2; i++) send_frame(1'b1, 8'h03, 1'b1, pbits[i], 1'b1);
            for (int k = 0; k < 2; k++) begin
                int wd; logic [9:0] ex;
                wd = 0;
                while (!m_valid_p && wd < RX_BUDGET) begin @(negedge clk); wd++; end
                checks++;
                if (!m_valid_p) begin errors++; $display("FAIL par_timeout: entry %0d m_valid=0 want 1", k); end
                else begin
                    ex = sb.pop_front();
                    if (m_data_p !== ex[7:0]) begin errors++; $display("FAIL par_data: got %h want %h", m_data_p, ex[7:0]); end
                    checks++; if (m_parity_err_p !== ex[9]) begin errors++; $display("FAIL par_err: entry %0d got %b want %b", k, m_parity_err_p, ex[9]); end
                    checks++; if (m_frame_err_p !== ex[8]) begin errors++; $display("FAIL par_frame_err: got %b want %b", m_frame_err_p, ex[8]); end
                    @(negedge clk);
                end
            end
        join
    endtask

    task automatic test_break();
        int b0;
        sb.delete(); b0 = brk_cnt;
        sb.push_back({1'b0, 1'b1, 8'h00});
        fork
            begin
                rx = 1'b0;
                repeat (12 * BIT_CLK) @(negedge clk);
                rx = 1'b1;
            end
            begin
                int wd; logic [9:0] ex;
                wd = 0;
                while (!m_valid && wd < RX_BUDGET) begin @(negedge clk); wd++; end
                checks++;
                if (!m_valid) begin errors++; $display("FAIL brk_timeout: m_valid=0 want 1"); end
                else begin
                    ex = sb.pop_front();
                    if (m_data !== ex[7:0]) begin errors++; $display("FAIL brk_data: got %h want %h", m_data, ex[7:0]); end
                    checks++; if (m_frame_err !== ex[8]) begin errors++; $display("FAIL brk_frame_err: got %b want %b", m_frame_err, ex[8]); end
                    @(negedge clk);
                end
            end
        join
        repeat (25 * BIT_CLK) @(negedge clk);
        checks++; if (brk_cnt - b0 != 1) begin errors++; $display("FAIL brk_pulses: got %0d want 1", brk_cnt - b0); end
    endtask

    task automatic test_overrun();
        int o0, exp_ovr;
        sb.delete(); o0 = ovr_cnt; exp_ovr = 0;
        m_ready = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            if (sb.size() < DEPTH) sb.push_back({2'b00, 8'h10 + 8'(i)});
            else exp_ovr++;
            send_frame(1'b0, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b1);
        end
        repeat (4) @(negedge clk);
        checks++; if (fifo_count !== 4'(DEPTH)) begin errors++; $display("FAIL ovr_count: got %0d want %0d", fifo_count, DEPTH); end
        checks++; if (ovr_cnt - o0 != exp_ovr) begin errors++; $display("FAIL ovr_pulses: got %0d want %0d", ovr_cnt - o0, exp_ovr); end
        m_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            int wd; logic [9:0] ex;
            wd = 0;
            while (!m_valid && wd < RX_BUDGET) begin @(negedge clk); wd++; end
            checks++;
            if (!m_valid) begin errors++; $display("FAIL ovr_timeout: entry %0d m_valid=0 want 1", k); end
            else begin
                ex = sb.pop_front();
                if (m_data !== ex[7:0]) begin errors++; $display("FAIL ovr_data: entry %0d got %h want %h", k, m_data, ex[7:0]); end
                @(negedge clk);
            end
        end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained: m_valid=%b want 0", m_valid); end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] d;
        int p0;
        d = 8'hC3;
        sb.delete(); p0 = pop_cnt;
        drive_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b0, d[i]);
        rx = d[4];
        repeat (BIT_CLK / 2) @(negedge clk);
        rst_n = 1'b0; rx = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * BIT_CLK) @(negedge clk);
        checks++; if (dut.r_state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d want IDLE", dut.r_state); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", m_valid); end
        sb.push_back({2'b00, 8'h3C});
        fork
            send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
            begin
                int wd; logic [9:0] ex;
                wd = 0;
                while (!m_valid && wd < RX_BUDGET) begin @(negedge clk); wd++; end
                checks++;
                if (!m_valid) begin errors++; $display("FAIL rstmid_timeout: m_valid=0 want 1"); end
                else begin
                    ex = sb.pop_front();
                    if (m_data !== ex[7:0]) begin errors++; $display("FAIL rstmid_data: got %h want %h", m_data, ex[7:0]); end
                    @(negedge clk);
                end
            end
        join
        repeat (2 * BIT_CLK) @(negedge clk);
        checks++; if (pop_cnt - p0 != 1) begin errors++; $display("FAIL rstmid_pops: got %0d want 1", pop_cnt - p0); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_glitch();
        test_parity();
        test_break();
        test_overrun();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Oversampling UART receiver with majority-vote bit sampling, optional parity, framing/break detection and an output FIFO with a valid/ready interface. It is the robust receive end for the existing 8N1 serial links. It samples each bit several times instead of once at mid-bit, and it buffers received bytes so slow consumers do not lose data. It sits between the RX pad and the register/DMA logic.

## Interface
- CLK_FREQ, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in bit/s.
- OVERSAMPLE, 16: samples per bit. Must be even and ≥ 8.
- PARITY_EN, 0: 1 = one parity bit follows the data bits.
- PARITY_ODD, 0: with PARITY_EN=1, 0 = even parity, 1 = odd parity.
- FIFO_DEPTH, 8: entries. Must be a power of 2 and ≥ 2.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- rx  in  1  asynchronous serial input. Idles high.
- m_data  out  8  byte at the FIFO head.
- m_frame_err  out  1  head entry had a bad stop bit.
- m_parity_err  out  1  head entry had a parity mismatch. Always 0 when PARITY_EN=0.
- m_valid  out  1  FIFO not empty.
- m_ready  in  1  consumer accepts the head entry.
- overrun  out  1  one-cycle pulse when a frame is dropped because the FIFO is full.
- break_det  out  1  one-cycle pulse on a break frame (all-zero data and bad stop bit).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

## Operation
- Input synchronizer: 2-flop, reset value 1. rx_s is the second stage.
- Tick generator:
  - TICK_DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer division (54 for the defaults).
  - The counter runs free and asserts tick for one clk every TICK_DIV clocks.
  - All FSM sampling happens only on tick cycles.
- Sample counter s counts 0..OVERSAMPLE-1 within a bit. M = OVERSAMPLE/2. The bit value is the majority of rx_s at s = M-1, M, M+1.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rx_s==0, go to START with s=0.
  - START: at s=M+1, evaluate the majority. If 0, continue and enter DATA at the bit wrap (s=OVERSAMPLE-1). If 1, it is a false start: return to IDLE immediately and push nothing.
  - DATA: 8 bits, LSB first. Shift in the majority value at s=M+1. After bit 7 wraps, go to PARITY if PARITY_EN=1, else STOP.
  - PARITY: parity_err = (XOR of data bits ^ parity bit ^ PARITY_ODD) != 0.
  - STOP: at s=M+1, frame_err = !majority. Push {parity_err, frame_err, data} and return to IDLE in the same cycle. The receiver does not wait out the second half of the stop bit, so it re-syncs on the next start edge.
- Break: frame_err=1 and data==8'h00 raises break_det with the push. The entry is still pushed, with m_frame_err=1.
- FIFO behaviour:
  - Show-ahead: m_data, m_frame_err and m_parity_err reflect the head whenever m_valid=1.
  - Pop on m_valid && m_ready.
  - Push when full with no simultaneous pop: the frame is dropped, overrun pulses, and FIFO contents are unchanged.
  - Push while full with a pop in the same cycle: both are performed and fifo_count stays at FIFO_DEPTH.
  - Push and pop while not full and not empty: both are performed and the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - With m_valid=0, m_ready is ignored.
- Reset:
  - Reset can arrive mid-frame. It aborts the frame, empties the FIFO and returns the FSM to IDLE. No partial frame is ever pushed.
  - Reset values: m_valid=0, m_data=0, m_frame_err=0, m_parity_err=0, overrun=0, break_det=0, fifo_count=0.

## Timing
- rx to rx_s: 2 clk.
- Start detection waits for the first tick after rx_s falls, so it carries up to TICK_DIV clk of jitter.
- Push happens on the tick cycle of the stop bit's s=M+1. m_valid (if previously empty), overrun and break_det are visible on the following clk edge.
- Pop takes effect on the clk edge where m_valid && m_ready. The next head appears on the same edge.
- Throughput: 1 byte/clk out of the FIFO. Line rate in.
- Tolerated baud mismatch: at least ±3% (default rounding error is 0.46%).

## Structure
- Package uart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP);
  - the rx_entry_t struct {parity_err, frame_err, data[7:0]};
  - the majority3() function;
  - the tick-divisor computation as a function of the parameters.
- Sub-module uart_rx_fifo:
  - generic synchronous show-ahead FIFO of rx_entry_t, parameter DEPTH;
  - ports push, pop, full, empty, count;
  - implements the full-plus-pop push rule.

## Test plan
- Use uart_tx (100 MHz, 115200) as the source and send 8'hA5, 8'h5A, 8'h00, 8'hFF back-to-back with m_ready=1 → four pops in order, m_frame_err=0 on each, overrun never set.
- Drive a 3-sample (≈3×TICK_DIV clk) low glitch on an idle line → no push, FSM back in IDLE, fifo_count=0.
- PARITY_EN=1, PARITY_ODD=0: send 8'h03 with parity bit 1 → entry 8'h03 with m_parity_err=1. Send 8'h03 with parity bit 0 → m_parity_err=0.
- Hold rx low for 12 bit times then release → entry 8'h00 with m_frame_err=1 and a single break_det pulse.
- m_ready=0, send FIFO_DEPTH+2 bytes (8'h10 to 8'h19) → fifo_count=8 and 2 overrun pulses. Then set m_ready=1 → 8'h10 to 8'h17 drained in order.
- Assert rst_n=0 mid-way through data bit 4 of 8'hC3, release, then send 8'h3C → only 8'h3C is received.
